multiexp_feeder: RTL and testbench

Upstream companion to the multi-exponentiation core. It accepts one job of `NUM_IN` {point, scalar} pairs, holds them in a ping-pong buffer, and replays the full set `REPEAT` times as the bit-serial stream the core consumes. Each replayed beat is tagged on `ctl` with its input index. A second job loads while the first replays, so the core sees back-to-back jobs with no bubble.

---
 rtl/multiexp_feeder.sv | 140 ++++++++++++++
 tb/tb_multiexp_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiexp_feeder.sv
// rtl/multiexp_feeder.sv - ping-pong job buffer replaying {point, scalar} beats to the multi-exp core
module multiexp_feeder #(
  parameter int DAT_BITS = 1024,
  parameter int NUM_IN   = 4,
  parameter int REPEAT   = 256,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_in_val,
  output logic                o_in_rdy,
  input  logic [DAT_BITS-1:0] i_in_dat,
  input  logic                i_in_eop,
  output logic                o_out_val,
  input  logic                i_out_rdy,
  output logic [DAT_BITS-1:0] o_out_dat,
  output logic [CTL_BITS-1:0] o_out_ctl,
  output logic                o_out_sop,
  output logic                o_out_eop,
  output logic                o_out_err,
  output logic [MOD_BITS-1:0] o_out_mod
);
  localparam int IDX_W = $clog2(NUM_IN);
  localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic [REP_W-1:0] LAST_REP = REP_W'(REPEAT - 1);

  logic [DAT_BITS-1:0] r_mem [2][NUM_IN];
  logic [1:0]          r_full;
  logic [1:0]          r_err;
  logic                r_live;
  logic                r_ld_ptr;
  logic                r_iss_ptr;
  logic                r_rp_ptr;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [IDX_W-1:0]    r_iss_idx;
  logic [REP_W-1:0]    r_iss_rep;
  logic                r_out_val;
  logic [DAT_BITS-1:0] r_out_dat;
  logic [CTL_BITS-1:0] r_out_ctl;
  logic                r_out_sop;
  logic                r_out_eop;
  logic                r_out_err;

  logic                w_wr_en;
  logic                w_last_wr;
  logic                w_close;
  logic                w_close_err;
  logic                w_byp;
  logic                w_iss;
  logic                w_iss_last;
  logic                w_done;
  logic [DAT_BITS-1:0] w_iss_dat;
  logic                w_iss_err;

  assign o_in_rdy    = r_live & ~r_full[r_ld_ptr];
  assign w_wr_en     = i_in_val & o_in_rdy;
  assign w_last_wr   = (r_wr_idx == LAST_IDX);
  assign w_close     = w_wr_en & (i_in_eop | w_last_wr);
  assign w_close_err = ~(i_in_eop & w_last_wr);

  // A bank closing this cycle may be issued immediately; its first beat/flag bypass the storage.
  assign w_byp      = w_close & (r_ld_ptr == r_iss_ptr);
  assign w_iss      = (~r_out_val | i_out_rdy) & (r_full[r_iss_ptr] | w_byp);
  assign w_iss_last = (r_iss_idx == LAST_IDX) & (r_iss_rep == LAST_REP);
  assign w_done     = r_out_val & i_out_rdy & r_out_eop;
  assign w_iss_dat  = (w_wr_en && (r_ld_ptr == r_iss_ptr) && (r_wr_idx == r_iss_idx)) ?
                      i_in_dat : r_mem[r_iss_ptr][r_iss_idx];
  assign w_iss_err  = w_byp ? w_close_err : r_err[r_iss_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int b = 0; b < 2; b++)
        for (int e = 0; e < NUM_IN; e++)
          r_mem[b][e] <= '0;
      r_full    <= '0;
      r_err     <= '0;
      r_live    <= 1'b0;
      r_ld_ptr  <= 1'b0;
      r_iss_ptr <= 1'b0;
      r_rp_ptr  <= 1'b0;
      r_wr_idx  <= '0;
      r_iss_idx <= '0;
      r_iss_rep <= '0;
      r_out_val <= 1'b0;
      r_out_dat <= '0;
      r_out_ctl <= '0;
      r_out_sop <= 1'b0;
      r_out_eop <= 1'b0;
      r_out_err <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wr_en) begin
        r_mem[r_ld_ptr][r_wr_idx] <= i_in_dat;
        r_wr_idx <= w_close ? '0 : r_wr_idx + IDX_W'(1);
        if (w_close) begin
          r_full[r_ld_ptr] <= 1'b1;
          r_err[r_ld_ptr]  <= w_close_err;
          r_ld_ptr         <= ~r_ld_ptr;
        end
      end
      // Released banks are cleared so a short next job reads zeros in its unwritten slots.
      if (w_done) begin
        r_full[r_rp_ptr] <= 1'b0;
        for (int e = 0; e < NUM_IN; e++)
          r_mem[r_rp_ptr][e] <= '0;
        r_rp_ptr <= ~r_rp_ptr;
      end
      if (w_iss) begin
        r_out_val <= 1'b1;
        r_out_dat <= w_iss_dat;
        r_out_ctl <= CTL_BITS'(r_iss_idx);
        r_out_sop <= (r_iss_idx == '0) && (r_iss_rep == '0);
        r_out_eop <= w_iss_last;
        r_out_err <= w_iss_err;
        if (w_iss_last) begin
          r_iss_idx <= '0;
          r_iss_rep <= '0;
          r_iss_ptr <= ~r_iss_ptr;
        end else if (r_iss_idx == LAST_IDX) begin
          r_iss_idx <= '0;
          r_iss_rep <= r_iss_rep + REP_W'(1);
        end else begin
          r_iss_idx <= r_iss_idx + IDX_W'(1);
        end
      end else if (i_out_rdy) begin
        r_out_val <= 1'b0;
      end
    end
  end

  assign o_out_val = r_out_val;
  assign o_out_dat = r_out_dat;
  assign o_out_ctl = r_out_ctl;
  assign o_out_sop = r_out_sop;
  assign o_out_eop = r_out_eop;
  assign o_out_err = r_out_err;
  assign o_out_mod = '0;
endmodule

// File: tb/tb_multiexp_feeder.sv
// tb/tb_multiexp_feeder.sv - directed vector bench for multiexp_feeder
module tb_multiexp_feeder;
  localparam int DW = 16;
  localparam int NI = 4;
  localparam int RP = 8;
  localparam int NB = NI * RP;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_in_val = 1'b0;
  logic          o_in_rdy;
  logic [DW-1:0] i_in_dat = '0;
  logic          i_in_eop = 1'b0;
  logic          o_out_val;
  logic          i_out_rdy = 1'b1;
  logic [DW-1:0] o_out_dat;
  logic [7:0]    o_out_ctl;
  logic          o_out_sop;
  logic          o_out_eop;
  logic          o_out_err;
  logic [7:0]    o_out_mod;

  multiexp_feeder #(.DAT_BITS(DW), .NUM_IN(NI), .REPEAT(RP), .CTL_BITS(8), .MOD_BITS(8)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_in_val(i_in_val), .o_in_rdy(o_in_rdy), .i_in_dat(i_in_dat), .i_in_eop(i_in_eop),
    .o_out_val(o_out_val), .i_out_rdy(i_out_rdy), .o_out_dat(o_out_dat), .o_out_ctl(o_out_ctl),
    .o_out_sop(o_out_sop), .o_out_eop(o_out_eop), .o_out_err(o_out_err), .o_out_mod(o_out_mod)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            nb;
    logic [DW-1:0] base;
    bit            eop;
    bit            bp;
    logic [DW-1:0] ed [4];
    bit            eerr;
  } vec_t;

  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;

  int            pp_nb;
  int            pp_cyc [64];
  logic [DW-1:0] pp_dat [64];
  logic [7:0]    pp_ctl [64];
  logic          pp_sop [64];
  logic          pp_eop [64];
  logic          pp_err [64];
  logic          rdy_log [300];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int nb, input logic [DW-1:0] base, input bit eop,
                         input bit bp, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input logic [DW-1:0] e3, input bit eerr);
    vecs[i].nb = nb; vecs[i].base = base; vecs[i].eop = eop; vecs[i].bp = bp;
    vecs[i].ed[0] = e0; vecs[i].ed[1] = e1; vecs[i].ed[2] = e2; vecs[i].ed[3] = e3;
    vecs[i].eerr = eerr;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " val"}, 64'(o_out_val), 64'd0);
    chk({tag, " rdy"}, 64'(o_in_rdy), 64'd0);
    chk({tag, " flags"}, 64'({o_out_sop, o_out_eop, o_out_err}), 64'd0);
    chk({tag, " ctl"}, 64'(o_out_ctl), 64'd0);
    chk({tag, " dat"}, 64'(o_out_dat), 64'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_in_val = 1'b0; i_in_eop = 1'b0; i_out_rdy = 1'b1;
    step();
    chk_idle("reset_hold");
    step();
    i_rst = 1'b0;
    chk_idle("reset_first_cycle");
    step();
    chk("reset_rdy_second_cycle", 64'(o_in_rdy), 64'd1);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base, input bit eop_last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      i_in_val = 1'b1;
      i_in_dat = base + DW'(i);
      i_in_eop = eop_last && (i == n - 1);
      while (!o_in_rdy && t < 200) begin
        step();
        t++;
      end
      if (t >= 200) chk("load_rdy_timeout", 64'd0, 64'd1);
      step();
    end
    i_in_val = 1'b0;
    i_in_eop = 1'b0;
  endtask

  task automatic collect(input string tag, input bit bp, input logic [DW-1:0] ed [4], input bit eerr);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [DW+10:0] prev = '0;
    while (k < NB && cyc < 1000) begin
      if (stalled) begin
        chk($sformatf("%s stall_val c%0d", tag, cyc), 64'(o_out_val), 64'd1);
        chk($sformatf("%s stall_hold c%0d", tag, cyc),
            64'({o_out_dat, o_out_ctl, o_out_sop, o_out_eop, o_out_err}), 64'(prev));
      end
      i_out_rdy = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (o_out_val && i_out_rdy) begin
        chk($sformatf("%s b%0d dat", tag, k), 64'(o_out_dat), 64'(ed[k % NI]));
        chk($sformatf("%s b%0d ctl", tag, k), 64'(o_out_ctl), 64'(k % NI));
        chk($sformatf("%s b%0d sop", tag, k), 64'(o_out_sop), 64'(k == 0));
        chk($sformatf("%s b%0d eop", tag, k), 64'(o_out_eop), 64'(k == NB - 1));
        chk($sformatf("%s b%0d err", tag, k), 64'(o_out_err), 64'(eerr));
        k++;
      end
      stalled = o_out_val && !i_out_rdy;
      prev = {o_out_dat, o_out_ctl, o_out_sop, o_out_eop, o_out_err};
      step();
      cyc++;
    end
    i_out_rdy = 1'b1;
    chk({tag, " beat_count"}, 64'(k), 64'(NB));
  endtask

  initial begin
    logic [DW-1:0] ed [4];
    set_vec(0, 4, 16'h1000, 1, 0, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 0);
    set_vec(1, 4, 16'h1100, 1, 1, 16'h1100, 16'h1101, 16'h1102, 16'h1103, 0);
    set_vec(2, 2, 16'h2000, 1, 0, 16'h2000, 16'h2001, 16'h0000, 16'h0000, 1);
    set_vec(3, 1, 16'h2100, 1, 1, 16'h2100, 16'h0000, 16'h0000, 16'h0000, 1);
    set_vec(4, 3, 16'h2200, 1, 1, 16'h2200, 16'h2201, 16'h2202, 16'h0000, 1);
    set_vec(5, 4, 16'h2300, 0, 0, 16'h2300, 16'h2301, 16'h2302, 16'h2303, 1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      chk($sformatf("v%0d val_before_load", v), 64'(o_out_val), 64'd0);
      load(vecs[v].nb, vecs[v].base, vecs[v].eop);
      chk($sformatf("v%0d first_val_latency", v), 64'(o_out_val), 64'd1);
      collect($sformatf("v%0d", v), vecs[v].bp, vecs[v].ed, vecs[v].eerr);
      chk($sformatf("v%0d no_extra_beats", v), 64'(o_out_val), 64'd0);
    end

    // Missing eop: six beats, the first four form an errored job, the last two wait.
    do_reset();
    ed = '{16'h3000, 16'h3001, 16'h3002, 16'h3003};
    fork
      load(6, 16'h3000, 1'b0);
      collect("miss_job1", 1'b0, ed, 1'b1);
    join
    repeat (5) step();
    chk("miss_job2_waits", 64'(o_out_val), 64'd0);
    chk("miss_job2_rdy", 64'(o_in_rdy), 64'd1);
    load(2, 16'h3006, 1'b1);
    chk("miss_job2_latency", 64'(o_out_val), 64'd1);
    ed = '{16'h3004, 16'h3005, 16'h3006, 16'h3007};
    collect("miss_job2", 1'b0, ed, 1'b0);

    // Ping-pong: B loads during A's replay and follows A with no bubble.
    do_reset();
    load(4, 16'h4000, 1'b1);
    i_out_rdy = 1'b1;
    pp_nb = 0;
    fork
      begin
        load(4, 16'h5000, 1'b1);
        chk("pp_rdy_low_after_b", 64'(o_in_rdy), 64'd0);
      end
      begin
        for (int c = 0; c < 300 && pp_nb < 64; c++) begin
          rdy_log[c] = o_in_rdy;
          if (o_out_val) begin
            pp_cyc[pp_nb] = c; pp_dat[pp_nb] = o_out_dat; pp_ctl[pp_nb] = o_out_ctl;
            pp_sop[pp_nb] = o_out_sop; pp_eop[pp_nb] = o_out_eop; pp_err[pp_nb] = o_out_err;
            pp_nb++;
          end
          step();
          if (pp_nb == 64) rdy_log[c + 1] = o_in_rdy;
        end
      end
    join
    chk("pp_beat_count", 64'(pp_nb), 64'd64);
    if (pp_nb == 64) begin
      for (int k = 0; k < 64; k++) begin
        chk($sformatf("pp b%0d dat", k), 64'(pp_dat[k]),
            64'((k < NB ? 16'h4000 : 16'h5000) + 16'(k % NI)));
        chk($sformatf("pp b%0d ctl", k), 64'(pp_ctl[k]), 64'(k % NI));
        chk($sformatf("pp b%0d sop", k), 64'(pp_sop[k]), 64'(k % NB == 0));
        chk($sformatf("pp b%0d eop", k), 64'(pp_eop[k]), 64'(k % NB == NB - 1));
        chk($sformatf("pp b%0d err", k), 64'(pp_err[k]), 64'd0);
      end
      chk("pp_no_bubble", 64'(pp_cyc[NB] - pp_cyc[NB - 1]), 64'd1);
      chk("pp_rdy_full_at_a_eop", 64'(rdy_log[pp_cyc[NB - 1]]), 64'd0);
      chk("pp_rdy_return", 64'(rdy_log[pp_cyc[NB - 1] + 1]), 64'd1);
    end

    // Reset asserted for one cycle while beat 10 is presented.
    do_reset();
    load(4, 16'h6000, 1'b1);
    i_out_rdy = 1'b1;
    begin
      int k = 0;
      int c = 0;
      while (k < 10 && c < 100) begin
        if (o_out_val) k++;
        step();
        c++;
      end
      chk("rst_reached_beat10", 64'(k), 64'd10);
    end
    chk("rst_beat10_ctl", 64'(o_out_ctl), 64'd2);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk_idle("rst_mid_next_cycle");
    step();
    chk("rst_mid_rdy_back", 64'(o_in_rdy), 64'd1);
    chk("rst_mid_no_resume", 64'(o_out_val), 64'd0);
    load(4, 16'h7000, 1'b1);
    chk("rst_fresh_latency", 64'(o_out_val), 64'd1);
    ed = '{16'h7000, 16'h7001, 16'h7002, 16'h7003};
    collect("rst_fresh", 1'b0, ed, 1'b0);
    chk("rst_fresh_no_extra", 64'(o_out_val), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
